argmax_stream_topk: RTL

- Parametrised streaming classifier decision unit at the end of the NPU FC layer.
- Takes one class score per beat over a valid/ready stream and tracks the best and second-best score online, without buffering the frame.
- Emits the winning class index, the winning score and the top-1/top-2 margin through an output valid/ready handshake.
- Successor to the fixed 10-class, 12-bit argmax. Adds:
  - configurable width and class count;
  - runtime class count;
  - signed/unsigned compare;
  - back-pressure, frame abort and margin output.

---
 rtl/argmax_stream_topk_if.sv | 25 ++
 rtl/argmax_stream_topk.sv | 116 +++++++++++
 2 files changed

// File: rtl/argmax_stream_topk_if.sv
// Score-stream and result-stream handshake bundle for argmax_stream_topk.
// The master side drives scores and consumes results; the slave side is the unit itself.
interface argmax_stream_topk_if #(
  parameter int DW = 12,
  parameter int IW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [DW-1:0] out_max;
  logic [DW-1:0] out_margin;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_max, out_margin
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_max, out_margin
  );
endinterface

// File: rtl/argmax_stream_topk.sv
// Streaming argmax with top-2 margin: tracks the best and runner-up score of a
// frame online and hands the result downstream over a valid/ready handshake.
module argmax_stream_topk #(
  parameter int DW     = 12,
  parameter int N_MAX  = 10,
  parameter int IW     = $clog2(N_MAX),
  parameter int CW     = $clog2(N_MAX + 1),
  parameter int SIGNED = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] cfg_num_cls,
  input  logic          abort,
  argmax_stream_topk_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [DW-1:0] MIN_SCORE = (SIGNED != 0) ? {1'b1, {(DW-1){1'b0}}} : {DW{1'b0}};

  state_t        state, state_nxt;
  logic [IW-1:0] cnt;
  logic [CW-1:0] n_reg, n_first, n_cur;
  logic [DW-1:0] run_max, run_sec;
  logic [IW-1:0] run_idx;
  logic [DW-1:0] cand_max, cand_sec, cand_margin;
  logic [IW-1:0] cand_idx;
  logic          first, accept, last;

  function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  assign bus.in_ready  = (state != HOLD) || bus.out_ready;
  assign bus.out_valid = (state == HOLD);

  // The counter is zero exactly on the first beat of a frame, so that is where
  // the class count is sampled and where the running registers restart.
  always_comb begin
    n_first = cfg_num_cls;
    if (cfg_num_cls == '0 || cfg_num_cls > CW'(N_MAX)) n_first = CW'(N_MAX);
    first  = (cnt == '0);
    n_cur  = first ? n_first : n_reg;
    accept = bus.in_valid && bus.in_ready && !abort;
    last   = accept && (CW'(cnt) == n_cur - CW'(1));

    cand_max = run_max;
    cand_sec = run_sec;
    cand_idx = run_idx;
    if (first) begin
      cand_max = bus.in_data;
      cand_sec = MIN_SCORE;
      cand_idx = '0;
    end else if (gt(bus.in_data, run_max)) begin
      cand_sec = run_max;
      cand_max = bus.in_data;
      cand_idx = cnt;
    end else if (gt(bus.in_data, run_sec)) begin
      cand_sec = bus.in_data;
    end

    // max >= second, so the DW-bit wrapped difference is the exact distance.
    cand_margin = (n_cur == CW'(1)) ? {DW{1'b1}} : cand_max - cand_sec;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: begin
        if (abort)       state_nxt = IDLE;
        else if (accept) state_nxt = last ? HOLD : ACC;
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (last)        state_nxt = HOLD;
          else if (accept) state_nxt = ACC;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result registers only load on a completing beat, which in HOLD requires
  // out_ready, so a stalled result can never be overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      n_reg          <= '0;
      run_max        <= '0;
      run_sec        <= '0;
      run_idx        <= '0;
      bus.out_idx    <= '0;
      bus.out_max    <= '0;
      bus.out_margin <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (accept) begin
      cnt     <= last ? '0 : cnt + IW'(1);
      run_max <= cand_max;
      run_sec <= cand_sec;
      run_idx <= cand_idx;
      if (first) n_reg <= n_first;
      if (last) begin
        bus.out_idx    <= cand_idx;
        bus.out_max    <= cand_max;
        bus.out_margin <= cand_margin;
      end
    end
  end
endmodule
